aes_key_schedule: RTL and testbench

//   Sequential AES-128 key schedule. Loads a 128-bit cipher key and iterates the existing
//   one-round key expansion block (key in, round number 1..10, next key out) once per clock.

---
 rtl/aes_key_schedule.sv | 145 ++++++++++++++
 tb/tb_aes_key_schedule.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: expands one round key per clock into an 11-entry
// register file and serves round keys through a registered read port.
module aes_key_schedule #(
    parameter int unsigned LENGTH     = 128,
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] key_in,
    input  logic              key_load,
    output logic              busy,
    output logic              keys_ready,
    output logic              done,
    input  logic              rd_en,
    input  logic [3:0]        rd_round,
    output logic [LENGTH-1:0] rd_key,
    output logic              rd_valid
);

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        exp_round;
    logic [LENGTH-1:0] cur_q;
    logic [LENGTH-1:0] nxt;
    logic [LENGTH-1:0] rk_q [0:NUM_ROUNDS];
    logic [LENGTH-1:0] rd_key_q;
    logic              rd_valid_q;
    logic              done_q;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rcon(rnd), 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Keep the round number inside 1..10 even when the expander output is unused.
    assign exp_round = (state_q == StExpand) ? cnt_q : 4'd1;
    assign nxt       = expand(cur_q, exp_round);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (key_load) state_d = StExpand;
            StExpand: begin
                if (key_load)                state_d = StExpand;
                else if (cnt_q == LastRound) state_d = StReady;
            end
            StReady:  if (key_load) state_d = StExpand;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cur_q      <= '0;
            done_q     <= 1'b0;
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i <= int'(NUM_ROUNDS); i++) rk_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            if (key_load) begin
                rk_q[0] <= key_in;
                cur_q   <= key_in;
                cnt_q   <= 4'd1;
            end else if (state_q == StExpand) begin
                rk_q[cnt_q] <= nxt;
                cur_q       <= nxt;
                if (cnt_q == LastRound) done_q <= 1'b1;
                else                    cnt_q  <= cnt_q + 4'd1;
            end
            // Nonblocking reads see the pre-load contents on a simultaneous key_load.
            if (rd_en && state_q == StReady) begin
                rd_valid_q <= 1'b1;
                rd_key_q   <= (rd_round <= LastRound) ? rk_q[rd_round] : '0;
            end
        end
    end

    assign busy       = (state_q == StExpand);
    assign keys_ready = (state_q == StReady);
    assign done       = done_q;
    assign rd_key     = rd_key_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 and all-zero key schedules.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         keys_ready;
    logic         done;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    logic [127:0] fips [0:10];
    logic [127:0] fips_key;
    logic [127:0] zero_r1;
    logic [127:0] zero_r10;

    always #5 clk = ~clk;

    aes_key_schedule #(
        .LENGTH     (128),
        .NUM_ROUNDS (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
        .busy       (busy),
        .keys_ready (keys_ready),
        .done       (done),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (done !== 1'b1 && c < 30) begin
            tick();
            c++;
        end
    endtask

    task automatic read(input logic [3:0] r, input logic [127:0] exp, input string tag);
        rd_en    = 1'b1;
        rd_round = r;
        tick();
        rd_en    = 1'b0;
        check_eq({tag, "_valid"}, 128'(rd_valid), 128'd1);
        check_eq(tag, rd_key, exp);
    endtask

    initial begin
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[0]  = fips_key;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_r1  = 128'h62636363626363636263636362636363;
        zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst = 1'b1; key_in = '0; key_load = 1'b0; rd_en = 1'b0; rd_round = '0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_ready", 128'(keys_ready), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_rdvalid", 128'(rd_valid), 128'd0);
        check_eq("rst_rdkey", rd_key, 128'd0);

        // FIPS-197 key: 10 busy cycles then done
        load(fips_key);
        check_eq("t1_busy", 128'(busy), 128'd1);
        wait_done(cyc);
        check_eq("t1_latency", 128'(cyc), 128'd10);
        check_eq("t1_ready", 128'(keys_ready), 128'd1);
        check_eq("t1_busy_lo", 128'(busy), 128'd0);
        tick();
        check_eq("t1_done_pulse", 128'(done), 128'd0);
        read(4'd1, fips[1], "t1_r1");
        read(4'd10, fips[10], "t1_r10");
        read(4'd0, fips[0], "t1_r0");

        // All-zero key
        load(128'd0);
        check_eq("t2_ready_drop", 128'(keys_ready), 128'd0);
        wait_done(cyc);
        check_eq("t2_latency", 128'(cyc), 128'd10);
        read(4'd1, zero_r1, "t2_r1");
        read(4'd10, zero_r10, "t2_r10");

        // Abort at the 4th EXPAND cycle with the FIPS key
        load(128'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_no_early_done", 128'(done), 128'd0);
            tick();
        end
        load(fips_key);
        wait_done(cyc);
        check_eq("t3_latency", 128'(cyc), 128'd10);
        tick();
        for (int i = 0; i <= 10; i++) begin
            rd_en    = 1'b1;
            rd_round = 4'(i);
            tick();
            check_eq($sformatf("t3_r%0d_valid", i), 128'(rd_valid), 128'd1);
            check_eq($sformatf("t3_r%0d", i), rd_key, fips[i]);
        end
        rd_en = 1'b0;

        // Reset mid-expansion
        load(128'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_busy", 128'(busy), 128'd0);
        check_eq("t4_ready", 128'(keys_ready), 128'd0);
        rd_en = 1'b1; rd_round = 4'd1;
        tick();
        rd_en = 1'b0;
        check_eq("t4_rd_dropped", 128'(rd_valid), 128'd0);
        check_eq("t4_rdkey_cleared", rd_key, 128'd0);
        load(fips_key);
        wait_done(cyc);
        check_eq("t4_latency", 128'(cyc), 128'd10);
        read(4'd5, fips[5], "t4_r5");

        // Reads while busy are dropped; out-of-range reads return zero
        load(128'd0);
        rd_en = 1'b1; rd_round = 4'd1;
        tick();
        rd_en = 1'b0;
        check_eq("t5_busy_rd_valid", 128'(rd_valid), 128'd0);
        check_eq("t5_busy_rd_hold", rd_key, fips[5]);
        wait_done(cyc);
        check_eq("t5_done", 128'(done), 128'd1);
        read(4'd11, 128'd0, "t5_r11");
        read(4'd10, zero_r10, "t5_r10");
        read(4'd15, 128'd0, "t5_r15");

        // Read and reload on the same edge returns the pre-load key
        rd_en = 1'b1; rd_round = 4'd1; key_load = 1'b1; key_in = fips_key;
        tick();
        rd_en = 1'b0; key_load = 1'b0;
        check_eq("t5_same_edge_valid", 128'(rd_valid), 128'd1);
        check_eq("t5_same_edge_key", rd_key, zero_r1);
        check_eq("t5_same_edge_busy", 128'(busy), 128'd1);
        check_eq("t5_same_edge_ready", 128'(keys_ready), 128'd0);
        wait_done(cyc);
        check_eq("t5_latency", 128'(cyc), 128'd10);
        read(4'd1, fips[1], "t5_r1_new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
